// File: rtl/registro_yk_sat.sv
// Per-channel output register: rescales the 2N-bit accumulator to N-bit Q format
// with saturation, holds one word per channel and forwards samples on a 1-entry stream.
module registro_yk_sat #(
  parameter int N   = 25,
  parameter int F   = 8,
  parameter int CHW = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [2*N-1:0]            In,
  input  logic [CHW-1:0]            Ch,
  input  logic                      Finish,
  input  logic                      Clear,
  output logic [(2**CHW)*N-1:0]     Yk,
  output logic [(2**CHW)-1:0]       Yk_valid,
  output logic [(2**CHW)-1:0]       Ovf,
  output logic [N-1:0]              Out_data,
  output logic [CHW-1:0]            Out_ch,
  output logic                      Out_valid,
  input  logic                      Out_ready,
  output logic                      Lost
);

  localparam int CH = 2**CHW;

  logic [2*N-1:0] s1_in;
  logic [CHW-1:0] s1_ch;
  logic           s1_valid;

  logic [N-F:0]   head;
  logic [N-1:0]   cand;
  logic [N-1:0]   sat_val;
  logic           ovf_now;
  logic           take;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_in    <= '0;
      s1_ch    <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= Finish;
      if (Finish) begin
        s1_in <= In;
        s1_ch <= Ch;
      end
    end
  end

  // The kept word is bits [N+F-1:F]; it is exact only if every bit from the
  // sign down to its MSB agrees, otherwise clamp toward the sign.
  always_comb begin
    head    = s1_in[2*N-1:N+F-1];
    cand    = s1_in[N+F-1:F];
    ovf_now = !((&head) || !(|head));
    sat_val = cand;
    if (ovf_now) begin
      sat_val = s1_in[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
    take = !Out_valid || Out_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Yk       <= '0;
      Yk_valid <= '0;
      Ovf      <= '0;
    end else begin
      Yk_valid <= '0;
      Ovf      <= Clear ? '0 : Ovf;
      if (s1_valid) begin
        Yk[s1_ch*N +: N]  <= sat_val;
        Yk_valid[s1_ch]   <= 1'b1;
        if (ovf_now) begin
          Ovf[s1_ch] <= 1'b1;
        end
      end
    end
  end

  // A sample arriving while the buffer is full and not draining is dropped
  // from the stream only; the per-channel register above still updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Out_data  <= '0;
      Out_ch    <= '0;
      Out_valid <= 1'b0;
      Lost      <= 1'b0;
    end else begin
      if (s1_valid && take) begin
        Out_data  <= sat_val;
        Out_ch    <= s1_ch;
        Out_valid <= 1'b1;
      end else if (Out_valid && Out_ready) begin
        Out_valid <= 1'b0;
      end
      if (s1_valid && !take) begin
        Lost <= 1'b1;
      end else if (Clear) begin
        Lost <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_registro_yk_sat.sv
// Scoreboard bench for registro_yk_sat: directed cases plus randomized traffic
// checked against a queue-based reference model.
module tb_registro_yk_sat;

  localparam int N   = 25;
  localparam int F   = 8;
  localparam int CHW = 1;
  localparam int CH  = 2**CHW;
  localparam longint MAXV = (longint'(1) <<< (N-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (N-1));

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [2*N-1:0]       In;
  logic [CHW-1:0]       Ch;
  logic                 Finish, Clear, Out_ready;
  logic [CH*N-1:0]      Yk;
  logic [CH-1:0]        Yk_valid, Ovf;
  logic [N-1:0]         Out_data;
  logic [CHW-1:0]       Out_ch;
  logic                 Out_valid, Lost;

  registro_yk_sat #(.N(N), .F(F), .CHW(CHW)) dut (
    .clk(clk), .reset_n(reset_n), .In(In), .Ch(Ch), .Finish(Finish), .Clear(Clear),
    .Yk(Yk), .Yk_valid(Yk_valid), .Ovf(Ovf), .Out_data(Out_data), .Out_ch(Out_ch),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Lost(Lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [N-1:0] val;
    bit          ovf;
  } samp_t;

  samp_t pipe_q[$];
  samp_t exp_q[$];
  samp_t str_q[$];

  bit           fin_d;
  bit           m_occ;
  logic [N-1:0] m_data;
  int           m_ch;
  bit [CH-1:0]  m_ovf;
  bit           m_lost;
  logic [N-1:0] m_yk [CH];

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic samp_t ref_samp(int ch, longint x);
    samp_t s;
    longint q;
    q = x >>> F;
    s.ch  = ch;
    s.ovf = 1'b0;
    if (q > MAXV) begin
      q = MAXV;
      s.ovf = 1'b1;
    end else if (q < MINV) begin
      q = MINV;
      s.ovf = 1'b1;
    end
    s.val = q[N-1:0];
    return s;
  endfunction

  function automatic longint rnd_in();
    int sh;
    longint unsigned v;
    sh = $urandom_range(1, 2*N-1);
    v = {$urandom(), $urandom()};
    v = v & ((longint'(1) << sh) - 1);
    if ($urandom_range(0, 1) == 1) return -longint'(v);
    return longint'(v);
  endfunction

  // Reference: samples enter a 2-deep delay; the stream is a capacity-1 queue.
  always @(posedge clk or negedge reset_n) begin : model_p
    bit    arrive;
    samp_t s;
    if (!reset_n) begin
      fin_d = 1'b0;
      m_occ = 1'b0;
      m_data = '0;
      m_ch = 0;
      m_ovf = '0;
      m_lost = 1'b0;
      for (int c = 0; c < CH; c++) m_yk[c] = '0;
      pipe_q.delete();
      exp_q.delete();
      str_q.delete();
    end else begin
      arrive = fin_d;
      fin_d  = Finish;
      if (Clear) begin
        m_ovf  = '0;
        m_lost = 1'b0;
      end
      if (m_occ && Out_ready) m_occ = 1'b0;
      if (arrive && pipe_q.size() > 0) begin
        s = pipe_q.pop_front();
        m_yk[s.ch] = s.val;
        if (s.ovf) m_ovf[s.ch] = 1'b1;
        exp_q.push_back(s);
        if (!m_occ) begin
          m_occ  = 1'b1;
          m_data = s.val;
          m_ch   = s.ch;
          str_q.push_back(s);
        end else begin
          m_lost = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor_p
    samp_t s;
    logic [CH-1:0] onehot;
    if (Yk_valid != '0 || exp_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        chk("yk_valid_unexpected", 64'(Yk_valid), 64'(0));
      end else begin
        s = exp_q.pop_front();
        onehot = '0;
        onehot[s.ch] = 1'b1;
        chk("yk_valid", 64'(Yk_valid), 64'(onehot));
        chk("yk_sample", 64'(Yk[s.ch*N +: N]), 64'(s.val));
      end
    end
    for (int c = 0; c < CH; c++) chk("yk_hold", 64'(Yk[c*N +: N]), 64'(m_yk[c]));
    chk("ovf", 64'(Ovf), 64'(m_ovf));
    chk("lost", 64'(Lost), 64'(m_lost));
    chk("out_valid", 64'(Out_valid), 64'(m_occ));
    chk("out_data", 64'(Out_data), 64'(m_data));
    chk("out_ch", 64'(Out_ch), 64'(m_ch));
    if (Out_valid && Out_ready) begin
      if (str_q.size() == 0) begin
        chk("stream_unexpected", 64'(1), 64'(0));
      end else begin
        s = str_q.pop_front();
        chk("stream_data", 64'(Out_data), 64'(s.val));
        chk("stream_ch", 64'(Out_ch), 64'(s.ch));
      end
    end
  end

  task automatic step(bit fin, int ch, longint x, bit clr, bit rdy);
    @(posedge clk);
    #1;
    Finish    = fin;
    Ch        = ch[CHW-1:0];
    In        = x[2*N-1:0];
    Clear     = clr;
    Out_ready = rdy;
    if (fin) pipe_q.push_back(ref_samp(ch, x));
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, rdy);
  endtask

  initial begin
    reset_n = 1'b0;
    In = '0; Ch = '0; Finish = 1'b0; Clear = 1'b0; Out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    step(1, 0, 1280, 0, 1);
    idle(3, 1);
    step(1, 1, -1280, 0, 1);
    step(1, 1, -1, 0, 1);
    idle(3, 1);

    step(1, 0, longint'(1) << 40, 0, 1);
    step(1, 0, -(longint'(1) << 45), 0, 1);
    idle(3, 1);
    step(0, 0, 0, 1, 1);
    idle(2, 1);
    step(1, 0, longint'(1) << 40, 0, 1);
    step(0, 0, 0, 1, 1);
    idle(3, 1);

    step(0, 0, 0, 1, 0);
    step(1, 0, 1 << 8, 0, 0);
    step(1, 0, 2 << 8, 0, 0);
    idle(3, 0);
    idle(3, 1);

    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(1, i % CH, rnd_in(), 0, 1);
    idle(4, 1);

    step(1, 1, 1280, 0, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    idle(2, 1);
    #1 reset_n = 1'b1;
    step(1, 0, 1280, 0, 1);
    idle(3, 1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, CH-1), rnd_in(),
           $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    idle(10, 1);

    chk("pipe_drained", 64'(pipe_q.size()), 64'(0));
    chk("stream_drained", 64'(str_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
